fp16_add_sequencer: RTL

FP16_ADD_SEQUENCER -- requirements
Module: fp16_add_sequencer

---
 rtl/fp16_add_sequencer.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/fp16_add_sequencer.sv
// rtl/fp16_add_sequencer.sv - multi-cycle FP16 adder/subtractor with a valid/ready handshake
//
// Adds or subtracts two FP16 values one step per clock: ARRANGE orders the
// operands and catches the cancellation/infinity cases, ALIGN shifts the smaller
// mantissa one bit per cycle, ADD combines the mantissas, NORM shifts the result
// left one bit per cycle and DONE holds the result until it is taken.
// Rounding is not performed; shifted-out bits are truncated.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand pair a/b/sub is valid
//   in_ready   block can accept an operation (IDLE only)
//   a, b       FP16 operands (sign[15], exp[14:10], mant[9:0])
//   sub        1: a-b, 0: a+b
//   out_valid  result is valid (DONE only)
//   out_ready  consumer accepts the result
//   result     registered FP16 result
//   busy       high in every state except IDLE

module fp16_add_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARRANGE = 3'd1,
    ALIGN   = 3'd2,
    ADD     = 3'd3,
    NORM    = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t      state;
  logic [15:0] op_a;
  logic [15:0] op_b;       // b with the effective sign (b[15]^sub) folded in
  logic        sign_l;     // sign of L; reused as the result sign through NORM
  logic        sign_s;
  logic [4:0]  exp_r;      // L.exp; becomes the working exponent in ADD/NORM
  logic [4:0]  moves;
  logic [3:0]  shift_cnt;
  logic [10:0] lm;         // L mantissa; reused as the working mantissa in NORM
  logic [10:0] sm;

  // ARRANGE: operand ordering, A wins ties
  logic        a_is_l;
  logic [15:0] l_op;
  logic [15:0] s_op;

  assign a_is_l = (op_a[14:10] >= op_b[14:10]);
  assign l_op   = a_is_l ? op_a : op_b;
  assign s_op   = a_is_l ? op_b : op_a;

  // ADD: mantissa combine
  logic [11:0] sum12;
  logic [10:0] add_mant;
  logic [4:0]  add_exp;
  logic        add_sign;
  logic        add_inf;

  assign sum12 = {1'b0, lm} + {1'b0, sm};

  always_comb begin
    add_mant = sum12[10:0];
    add_exp  = exp_r;
    add_sign = sign_l;
    add_inf  = 1'b0;
    if (sign_l == sign_s) begin
      if (sum12[11]) begin
        add_mant = sum12[11:1];
        add_exp  = exp_r + 5'd1;
        add_inf  = (exp_r == 5'd30);
      end
    end else if (lm >= sm) begin
      add_mant = lm - sm;
    end else begin
      // Only reachable with equal exponents, where S can be the larger magnitude
      add_mant = sm - lm;
      add_sign = sign_s;
    end
  end

  // NORM: one left shift per cycle
  logic [10:0] norm_mant;
  logic [4:0]  norm_exp;

  assign norm_mant = {lm[9:0], 1'b0};
  assign norm_exp  = exp_r - 5'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= 16'h0000;
      op_a      <= 16'h0000;
      op_b      <= 16'h0000;
      sign_l    <= 1'b0;
      sign_s    <= 1'b0;
      exp_r     <= 5'd0;
      moves     <= 5'd0;
      shift_cnt <= 4'd0;
      lm        <= 11'd0;
      sm        <= 11'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_a     <= a;
            op_b     <= {b[15] ^ sub, b[14:0]};
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ARRANGE;
          end else begin
            in_ready <= 1'b1;
          end
        end

        ARRANGE: begin
          if ((op_a[14:0] == op_b[14:0]) && (op_a[15] != op_b[15])) begin
            result    <= 16'h0000;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (op_a[14:10] == 5'h1F) begin
            result    <= {op_a[15], 5'h1F, 10'h000};
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (op_b[14:10] == 5'h1F) begin
            result    <= {op_b[15], 5'h1F, 10'h000};
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            sign_l    <= l_op[15];
            sign_s    <= s_op[15];
            exp_r     <= l_op[14:10];
            moves     <= l_op[14:10] - s_op[14:10];
            lm        <= {l_op[14:10] != 5'd0, l_op[9:0]};
            sm        <= {s_op[14:10] != 5'd0, s_op[9:0]};
            shift_cnt <= 4'd0;
            // Equal exponents need no alignment, so ALIGN is skipped entirely
            state     <= (l_op[14:10] == s_op[14:10]) ? ADD : ALIGN;
          end
        end

        ALIGN: begin
          sm        <= sm >> 1;
          moves     <= moves - 5'd1;
          shift_cnt <= shift_cnt + 4'd1;
          // After 11 shifts S is all zeros, so further shifting is pointless
          if ((moves == 5'd1) || (shift_cnt == 4'd10)) begin
            state <= ADD;
          end
        end

        ADD: begin
          if (add_inf) begin
            result    <= {add_sign, 5'h1F, 10'h000};
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (add_mant == 11'd0) begin
            result    <= 16'h0000;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (add_mant[10]) begin
            result    <= {add_sign, add_exp, add_mant[9:0]};
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (exp_r <= 5'd1) begin
            // No room to normalise: flush to signed zero
            result    <= {add_sign, 15'h0000};
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            lm     <= add_mant;
            sign_l <= add_sign;
            state  <= NORM;
          end
        end

        NORM: begin
          if (norm_mant[10]) begin
            result    <= {sign_l, norm_exp, norm_mant[9:0]};
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (norm_exp == 5'd1) begin
            result    <= {sign_l, 15'h0000};
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            lm    <= norm_mant;
            exp_r <= norm_exp;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
